// File: rtl/tx_chk_pkg.sv
// Shared types and helpers for the CAN transmit-buffer frame checker.
// The payload width follows MAX_BYTES, so the frame struct carries only the header here.
package tx_chk_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StCapture,
        StCompare
    } chk_state_e;

    localparam int unsigned ERR_RTR   = 0;
    localparam int unsigned ERR_DLC   = 1;
    localparam int unsigned ERR_BUSY  = 2;
    localparam int unsigned ERR_BYTE0 = 3;

    typedef struct packed {
        logic       rtr;
        logic [3:0] dlc;
    } exp_hdr_t;

    // Remote frames carry no payload; DLC above 8 means a full payload.
    function automatic int unsigned cmp_byte_cnt(input logic rtr, input logic [3:0] dlc,
                                                 input int unsigned max_bytes);
        int unsigned n;
        if (rtr) begin
            n = 0;
        end else if (dlc > 4'd8) begin
            n = max_bytes;
        end else if (32'(dlc) < max_bytes) begin
            n = 32'(dlc);
        end else begin
            n = max_bytes;
        end
        return n;
    endfunction

endpackage

// File: rtl/tx_frame_checker_if.sv
// Expected-frame push port: valid/ready handshake plus the frame fields.
interface tx_frame_checker_if #(
    parameter int unsigned MAX_BYTES = 8
) ();
    logic                   exp_valid;
    logic                   exp_ready;
    logic                   exp_rtr;
    logic [3:0]             exp_dlc;
    logic [8*MAX_BYTES-1:0] exp_data;

    modport master (
        output exp_valid,
        output exp_rtr,
        output exp_dlc,
        output exp_data,
        input  exp_ready
    );

    modport slave (
        input  exp_valid,
        input  exp_rtr,
        input  exp_dlc,
        input  exp_data,
        output exp_ready
    );
endinterface

// File: rtl/tx_chk_fifo.sv
// Synchronous FIFO with first-word-fall-through head for expected frames.
module tx_chk_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 69
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);
    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wptr_q;
    logic [AW:0]      rptr_q;
    logic             do_push;
    logic             do_pop;

    // Admission depends only on full, so a same-cycle pop never frees a slot early.
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    assign empty = (wptr_q == rptr_q);
    assign full  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
    assign rdata = mem[rptr_q[AW-1:0]];

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            if (do_push) wptr_q <= wptr_q + 1'b1;
            if (do_pop)  rptr_q <= rptr_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wptr_q[AW-1:0]] <= wdata;
    end

endmodule

// File: rtl/tx_frame_checker.sv
// Monitors the CAN transmit buffer: on each frame-generation strobe the live outputs are
// compared against the next queued expected frame, with statistics and a watchdog.
module tx_frame_checker
    import tx_chk_pkg::*;
#(
    parameter int unsigned MAX_BYTES = 8,
    parameter int unsigned DEPTH     = 4,
    parameter int unsigned CNT_W     = 16,
    parameter int unsigned TIMEOUT   = 1024
) (
    input  logic                   clk,
    input  logic                   rst,
    tx_frame_checker_if.slave      exp,
    input  logic                   frame_gen_intl,
    input  logic                   tx_buff_busy,
    input  logic [8*MAX_BYTES-1:0] tx_buff_data,
    input  logic                   rtr,
    input  logic [3:0]             dlc,
    output logic                   chk_done,
    output logic                   chk_pass,
    output logic [MAX_BYTES+2:0]   chk_err_mask,
    output logic [CNT_W-1:0]       pass_cnt,
    output logic [CNT_W-1:0]       fail_cnt,
    output logic [CNT_W-1:0]       unexp_cnt,
    output logic                   timeout,
    output logic                   overrun
);
    localparam int unsigned MASK_W = MAX_BYTES + 3;
    localparam int unsigned FW     = 5 + 8 * MAX_BYTES;
    localparam int unsigned WD_W   = $clog2(TIMEOUT + 1);

    typedef struct packed {
        exp_hdr_t               hdr;
        logic [8*MAX_BYTES-1:0] data;
    } frame_t;

    chk_state_e             state_q, state_d;
    logic                   fgi_q;
    logic                   strb;
    logic                   cap_rtr_q;
    logic [3:0]             cap_dlc_q;
    logic [8*MAX_BYTES-1:0] cap_data_q;
    logic                   cap_busy_q;
    logic [MASK_W-1:0]      mask_q;
    logic [MASK_W-1:0]      mask_calc;
    logic [MASK_W-1:0]      mask_new;
    logic                   pass_q;
    logic [CNT_W-1:0]       pass_cnt_q, fail_cnt_q, unexp_cnt_q;
    logic [WD_W-1:0]        wd_q;
    logic                   timeout_q;
    logic                   overrun_q;
    int unsigned            n_cmp;

    frame_t                 push_frame;
    frame_t                 head;
    logic                   fifo_full;
    logic                   fifo_empty;
    logic                   fifo_pop;

    assign strb       = frame_gen_intl && !fgi_q;
    assign push_frame = {exp.exp_rtr, exp.exp_dlc, exp.exp_data};
    assign exp.exp_ready = !fifo_full;
    assign fifo_pop   = (state_q == StCapture) && !fifo_empty;

    tx_chk_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (FW)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (exp.exp_valid),
        .wdata (push_frame),
        .pop   (fifo_pop),
        .rdata (head),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    always_comb begin
        n_cmp     = cmp_byte_cnt(head.hdr.rtr, head.hdr.dlc, MAX_BYTES);
        mask_calc = '0;
        mask_calc[ERR_RTR]  = (cap_rtr_q != head.hdr.rtr);
        mask_calc[ERR_DLC]  = (cap_dlc_q != head.hdr.dlc);
        mask_calc[ERR_BUSY] = !cap_busy_q;
        for (int unsigned i = 0; i < MAX_BYTES; i++) begin
            if (i < n_cmp) begin
                mask_calc[ERR_BYTE0 + i] = (cap_data_q[8*i +: 8] != head.data[8*i +: 8]);
            end
        end
        mask_new = fifo_empty ? '1 : mask_calc;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:    if (strb) state_d = StCapture;
            StCapture: state_d = StCompare;
            StCompare: state_d = StIdle;
            default:   state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) state_q <= StIdle;
        else     state_q <= state_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fgi_q       <= 1'b0;
            cap_rtr_q   <= 1'b0;
            cap_dlc_q   <= '0;
            cap_data_q  <= '0;
            cap_busy_q  <= 1'b0;
            mask_q      <= '0;
            pass_q      <= 1'b0;
            pass_cnt_q  <= '0;
            fail_cnt_q  <= '0;
            unexp_cnt_q <= '0;
            overrun_q   <= 1'b0;
        end else begin
            fgi_q <= frame_gen_intl;
            if (state_q == StIdle && strb) begin
                cap_rtr_q  <= rtr;
                cap_dlc_q  <= dlc;
                cap_data_q <= tx_buff_data;
                cap_busy_q <= tx_buff_busy;
            end
            if (state_q != StIdle && strb) overrun_q <= 1'b1;
            if (state_q == StCapture) begin
                mask_q <= mask_new;
                pass_q <= (mask_new == '0);
                if (fifo_empty && unexp_cnt_q != '1) unexp_cnt_q <= unexp_cnt_q + 1'b1;
            end
            if (state_q == StCompare) begin
                if (pass_q) begin
                    if (pass_cnt_q != '1) pass_cnt_q <= pass_cnt_q + 1'b1;
                end else begin
                    if (fail_cnt_q != '1) fail_cnt_q <= fail_cnt_q + 1'b1;
                end
            end
        end
    end

    // Watchdog only runs while a frame is pending and no check is in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            wd_q      <= '0;
            timeout_q <= 1'b0;
        end else if (fifo_empty || strb) begin
            wd_q <= '0;
        end else if (state_q == StIdle) begin
            if (wd_q != WD_W'(TIMEOUT)) wd_q <= wd_q + 1'b1;
            if (wd_q == WD_W'(TIMEOUT - 1)) timeout_q <= 1'b1;
        end
    end

    assign chk_done     = (state_q == StCompare);
    assign chk_pass     = pass_q;
    assign chk_err_mask = mask_q;
    assign pass_cnt     = pass_cnt_q;
    assign fail_cnt     = fail_cnt_q;
    assign unexp_cnt    = unexp_cnt_q;
    assign timeout      = timeout_q;
    assign overrun      = overrun_q;

endmodule

// File: tb/tb_tx_frame_checker.sv
// Directed self-checking bench for tx_frame_checker with hand-computed expectations.
module tb_tx_frame_checker;
    localparam int unsigned MAX_BYTES = 8;
    localparam int unsigned DEPTH     = 4;
    localparam int unsigned CNT_W     = 16;
    localparam int unsigned TIMEOUT   = 64;

    logic                   clk = 1'b0;
    logic                   rst;
    logic                   frame_gen_intl;
    logic                   tx_buff_busy;
    logic [8*MAX_BYTES-1:0] tx_buff_data;
    logic                   rtr;
    logic [3:0]             dlc;
    logic                   chk_done;
    logic                   chk_pass;
    logic [MAX_BYTES+2:0]   chk_err_mask;
    logic [CNT_W-1:0]       pass_cnt, fail_cnt, unexp_cnt;
    logic                   timeout;
    logic                   overrun;

    int n_checks = 0;
    int n_errors = 0;
    int e_pass   = 0;
    int e_fail   = 0;
    int e_unexp  = 0;

    tx_frame_checker_if #(.MAX_BYTES(MAX_BYTES)) exp_bus ();

    tx_frame_checker #(
        .MAX_BYTES (MAX_BYTES),
        .DEPTH     (DEPTH),
        .CNT_W     (CNT_W),
        .TIMEOUT   (TIMEOUT)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .exp            (exp_bus.slave),
        .frame_gen_intl (frame_gen_intl),
        .tx_buff_busy   (tx_buff_busy),
        .tx_buff_data   (tx_buff_data),
        .rtr            (rtr),
        .dlc            (dlc),
        .chk_done       (chk_done),
        .chk_pass       (chk_pass),
        .chk_err_mask   (chk_err_mask),
        .pass_cnt       (pass_cnt),
        .fail_cnt       (fail_cnt),
        .unexp_cnt      (unexp_cnt),
        .timeout        (timeout),
        .overrun        (overrun)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish, errors=%0d", n_errors);
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] want);
        n_checks++;
        if (got !== want) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, want);
        end
    endtask

    task automatic push(input logic r, input logic [3:0] d, input logic [63:0] data);
        exp_bus.exp_valid = 1'b1;
        exp_bus.exp_rtr   = r;
        exp_bus.exp_dlc   = d;
        exp_bus.exp_data  = data;
        tick();
        exp_bus.exp_valid = 1'b0;
    endtask

    task automatic drive(input logic r, input logic [3:0] d, input logic [63:0] data,
                         input logic busy);
        rtr          = r;
        dlc          = d;
        tx_buff_data = data;
        tx_buff_busy = busy;
    endtask

    task automatic check_counts(input string tag);
        check_eq({tag, "_pass_cnt"}, 64'(pass_cnt), 64'(e_pass));
        check_eq({tag, "_fail_cnt"}, 64'(fail_cnt), 64'(e_fail));
        check_eq({tag, "_unexp_cnt"}, 64'(unexp_cnt), 64'(e_unexp));
    endtask

    // One strobe, then result two cycles later and counters the cycle after.
    task automatic run_check(input string tag, input logic [10:0] want_mask, input bit unexp);
        frame_gen_intl = 1'b1;
        tick();
        frame_gen_intl = 1'b0;
        check_eq({tag, "_early"}, 64'(chk_done), 64'd0);
        tick();
        check_eq({tag, "_done"}, 64'(chk_done), 64'd1);
        check_eq({tag, "_pass"}, 64'(chk_pass), 64'(want_mask == 11'd0));
        check_eq({tag, "_mask"}, 64'(chk_err_mask), 64'(want_mask));
        if (unexp) e_unexp++;
        if (want_mask == 11'd0) e_pass++;
        else                    e_fail++;
        tick();
        check_eq({tag, "_done_low"}, 64'(chk_done), 64'd0);
        check_eq({tag, "_mask_hold"}, 64'(chk_err_mask), 64'(want_mask));
        check_counts(tag);
    endtask

    initial begin
        int ndone;
        rst               = 1'b1;
        frame_gen_intl    = 1'b0;
        exp_bus.exp_valid = 1'b0;
        exp_bus.exp_rtr   = 1'b0;
        exp_bus.exp_dlc   = 4'd0;
        exp_bus.exp_data  = '0;
        drive(1'b0, 4'd0, 64'd0, 1'b1);
        repeat (3) tick();
        rst = 1'b0;
        tick();
        check_eq("rst_done", 64'(chk_done), 64'd0);
        check_eq("rst_pass", 64'(chk_pass), 64'd0);
        check_eq("rst_mask", 64'(chk_err_mask), 64'd0);
        check_eq("rst_ready", 64'(exp_bus.exp_ready), 64'd1);
        check_eq("rst_timeout", 64'(timeout), 64'd0);
        check_eq("rst_overrun", 64'(overrun), 64'd0);
        check_counts("rst");

        // Exact match, full payload.
        push(1'b0, 4'd8, 64'h0807060504030201);
        drive(1'b0, 4'd8, 64'h0807060504030201, 1'b1);
        run_check("match8", 11'h000, 1'b0);

        // Byte 1 differs; bytes past DLC are garbage and must be ignored.
        push(1'b0, 4'd2, 64'h000000000000BBAA);
        drive(1'b0, 4'd2, 64'h112233445566BCAA, 1'b1);
        run_check("byte1", 11'h010, 1'b0);

        // Remote frame: payload not compared, DLC still is.
        push(1'b1, 4'd4, 64'd0);
        drive(1'b1, 4'd4, 64'hFFFF000012345678, 1'b1);
        run_check("rtr_ok", 11'h000, 1'b0);
        push(1'b1, 4'd4, 64'd0);
        drive(1'b1, 4'd5, 64'hFFFF000012345678, 1'b1);
        run_check("rtr_dlc", 11'h002, 1'b0);

        push(1'b0, 4'd1, 64'h5A);
        drive(1'b0, 4'd1, 64'h5A, 1'b0);
        run_check("busy_low", 11'h004, 1'b0);

        // DLC 12 compares all 8 bytes; only the top byte differs.
        push(1'b0, 4'd12, 64'h8877665544332211);
        drive(1'b0, 4'd12, 64'h9977665544332211, 1'b1);
        run_check("dlc12", 11'h400, 1'b0);

        drive(1'b0, 4'd0, 64'd0, 1'b1);
        run_check("empty", 11'h7FF, 1'b1);

        for (int i = 0; i < DEPTH; i++) push(1'b0, 4'd8, 64'(i + 1) * 64'h0101010101010101);
        check_eq("full_ready", 64'(exp_bus.exp_ready), 64'd0);
        push(1'b0, 4'd8, 64'hEEEEEEEEEEEEEEEE);
        check_eq("full_ready2", 64'(exp_bus.exp_ready), 64'd0);
        for (int i = 0; i < DEPTH; i++) begin
            drive(1'b0, 4'd8, 64'(i + 1) * 64'h0101010101010101, 1'b1);
            run_check($sformatf("drain%0d", i), 11'h000, 1'b0);
        end
        check_eq("drained_ready", 64'(exp_bus.exp_ready), 64'd1);
        run_check("after_full", 11'h7FF, 1'b1);
        check_eq("overrun_clear", 64'(overrun), 64'd0);

        // Watchdog with one frame pending.
        push(1'b0, 4'd3, 64'h0000000000C0FFEE);
        repeat (TIMEOUT - 14) tick();
        check_eq("wd_early", 64'(timeout), 64'd0);
        repeat (20) tick();
        check_eq("wd_fired", 64'(timeout), 64'd1);

        // Second strobe lands while the first check is in flight.
        drive(1'b0, 4'd3, 64'h0000000000C0FFEE, 1'b1);
        ndone = 0;
        frame_gen_intl = 1'b1;
        tick();
        ndone += int'(chk_done);
        frame_gen_intl = 1'b0;
        tick();
        ndone += int'(chk_done);
        frame_gen_intl = 1'b1;
        tick();
        ndone += int'(chk_done);
        frame_gen_intl = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick();
            ndone += int'(chk_done);
        end
        e_pass++;
        check_eq("ovr_flag", 64'(overrun), 64'd1);
        check_eq("ovr_single_done", 64'(ndone), 64'd1);
        check_eq("ovr_pass", 64'(chk_pass), 64'd1);
        check_eq("wd_sticky", 64'(timeout), 64'd1);
        check_counts("ovr");

        // Reset during CAPTURE drops the result and the queue.
        push(1'b0, 4'd1, 64'h77);
        drive(1'b0, 4'd1, 64'h77, 1'b1);
        frame_gen_intl = 1'b1;
        tick();
        frame_gen_intl = 1'b0;
        rst = 1'b1;
        tick();
        check_eq("mid_rst_done", 64'(chk_done), 64'd0);
        rst = 1'b0;
        tick();
        e_pass  = 0;
        e_fail  = 0;
        e_unexp = 0;
        check_eq("post_rst_done", 64'(chk_done), 64'd0);
        check_eq("post_rst_ready", 64'(exp_bus.exp_ready), 64'd1);
        check_eq("post_rst_timeout", 64'(timeout), 64'd0);
        check_eq("post_rst_overrun", 64'(overrun), 64'd0);
        check_eq("post_rst_mask", 64'(chk_err_mask), 64'd0);
        check_counts("post_rst");
        run_check("post_rst_empty", 11'h7FF, 1'b1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
